pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Upstream stage of the score system. It runs one round: an idle wait, a start countdown, then NUM_PATTERNS arrow prompts separated by gaps, and finally game over. For each prompt it generates pseudo-random one-hot arrows for players A and B and a per-prompt cycle timer. Its outputs game_active, game_over, pattern_a, pattern_b, pattern_valid and pattern_timer drive the score tracker's ports of the same names directly.

Parameters:
NUM_PATTERNS, 32, prompts per round (1..255)
WINDOW_CYCLES, 500_000, cycles each prompt is valid (2..2^20); must be >= the tracker's total hit window
GAP_CYCLES, 100_000, idle cycles between prompts (>=1)
COUNTDOWN_CYCLES, 150_000_000, cycles from start to first prompt (>=1, counter 28 bits)
DEFAULT_SEED, 16'hACE1, LFSR seed used when the seed input is 0

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
start  in  1  level; sampled in IDLE/OVER to begin a round
abort  in  1  level; ends the round immediately; has priority over start
seed  in  16  LFSR seed, loaded when start is accepted
game_active  out  1  high in SHOW and GAP
game_over  out  1  high in OVER
pattern_a  out  4  one-hot arrow for A (UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000); 0 when not valid
pattern_b  out  4  one-hot arrow for B; 0 when not valid
pattern_valid  out  1  high in SHOW
pattern_timer  out  20  cycles since the current prompt started; 0 outside SHOW
pattern_index  out  8  prompts completed this round
countdown_busy  out  1  high in COUNTDOWN

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-low) sets: state IDLE, all outputs 0, LFSR = DEFAULT_SEED, counters 0. Reset mid-round aborts silently, with no game_over pulse.
- FSM states: IDLE, COUNTDOWN, SHOW, GAP, OVER.
- IDLE:
  - start=1 and abort=0 -> COUNTDOWN next edge.
  - On that edge: LFSR <= (seed==0 ? DEFAULT_SEED : seed); pattern_index <= 0; cycle counter <= 0.
- COUNTDOWN:
  - countdown_busy=1; the counter increments each cycle.
  - At count == COUNTDOWN_CYCLES-1 -> SHOW.
- SHOW:
  - On entry: pattern_a <= 1 << lfsr[1:0]; pattern_b <= 1 << lfsr[3:2]; pattern_valid <= 1; pattern_timer <= 0; game_active <= 1.
  - pattern_timer increments each cycle and therefore reads 0..WINDOW_CYCLES-1.
  - At pattern_timer == WINDOW_CYCLES-1 -> GAP.
  - On that edge: pattern_valid, pattern_a, pattern_b and pattern_timer <= 0; pattern_index increments; LFSR advances one step.
- LFSR: Fibonacci, fb = l[15]^l[13]^l[12]^l[10], next = {l[14:0], fb}. It never steps outside the SHOW->GAP transition.
- GAP:
  - game_active stays 1; the counter runs GAP_CYCLES cycles.
  - Then: pattern_index == NUM_PATTERNS -> OVER, otherwise -> SHOW.
  - The final prompt is therefore followed by one gap before OVER.
- OVER:
  - game_over=1 and game_active=0, held.
  - start=1 (with abort=0) -> COUNTDOWN with a full re-initialisation as from IDLE; game_over clears on that edge.
  - pattern_index holds its final value until the restart.
- abort=1 in COUNTDOWN, SHOW or GAP -> OVER next edge: pattern_valid drops, patterns and timer clear, pattern_index holds.
- abort in IDLE or OVER is ignored.
- Simultaneous start and abort in IDLE/OVER: no action.
- start held continuously: a new round begins automatically on the first OVER cycle. This is intended; the top level synchronises and edge-detects the button.
- pattern_a and pattern_b may be equal; no constraint is applied.

Decomposition:
- Shared package holds:
  - Arrow encodings UP, DOWN, LEFT, RIGHT, NONE.
  - State enum.
  - Window constants (PERFECT/GOOD/TOTAL) shared with the score tracker.
  - DEFAULT_SEED and the LFSR tap mask.
- Sub-module lfsr16 (load, step, seed, value), with one instance per block. The FSM and counters stay in pattern_sequencer.

Test Plan:
Use COUNTDOWN_CYCLES=4, WINDOW_CYCLES=8, GAP_CYCLES=2, NUM_PATTERNS=3 throughout.
1. Reset: assert reset=0 mid-SHOW -> all outputs 0 immediately (asynchronous); after release the FSM is in IDLE.
2. Start with seed=16'hACE1 -> countdown_busy for 4 cycles; then pattern_valid=1, pattern_a=0010, pattern_b=0001, pattern_timer steps 0..7, then valid drops for 2 cycles.
3. Second prompt -> LFSR=16'h59C3, so pattern_a=1000, pattern_b=0001, pattern_index=1 during it.
4. Full round -> game_over rises exactly 34 cycles after the start-accept edge, with game_active=0 and pattern_index=3; it holds until the next start.
5. abort during the second prompt at pattern_timer=5 -> next cycle: OVER, pattern_valid=0, timer=0, pattern_index=1, game_over=1.
6. seed=0 on start -> first prompt identical to scenario 2 (DEFAULT_SEED used). Restart from OVER -> game_over clears and the countdown begins on the accept edge.

Source files
------------

// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the pattern sequencer and the score tracker:
// arrow encodings, FSM states, hit-window constants and LFSR helpers.
package pattern_sequencer_pkg;

  localparam logic [3:0] ARROW_NONE  = 4'b0000;
  localparam logic [3:0] ARROW_UP    = 4'b0001;
  localparam logic [3:0] ARROW_DOWN  = 4'b0010;
  localparam logic [3:0] ARROW_LEFT  = 4'b0100;
  localparam logic [3:0] ARROW_RIGHT = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_SHOW,
    ST_GAP,
    ST_OVER
  } state_e;

  // Hit windows used by the score tracker; the prompt window must cover TOTAL.
  localparam int unsigned PERFECT_WINDOW = 100_000;
  localparam int unsigned GOOD_WINDOW    = 250_000;
  localparam int unsigned TOTAL_WINDOW   = 400_000;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] arrow_of(input logic [1:0] sel);
    return ARROW_UP << sel;
  endfunction

endpackage

// File: rtl/pattern_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load (priority) and single-step enable.
module lfsr16
  import pattern_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VALUE = pattern_sequencer_pkg::DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= RESET_VALUE;
    end else if (load_i) begin
      value_q <= seed_i;
    end else if (step_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Round sequencer: idle, countdown, NUM_PATTERNS prompts with gaps, game over.
// Every output comes straight from a register.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS     = 32,
  parameter int unsigned WINDOW_CYCLES    = 500_000,
  parameter int unsigned GAP_CYCLES       = 100_000,
  parameter int unsigned COUNTDOWN_CYCLES = 150_000_000,
  parameter logic [15:0] DEFAULT_SEED     = pattern_sequencer_pkg::DEFAULT_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] seed,
  output logic        game_active,
  output logic        game_over,
  output logic [3:0]  pattern_a,
  output logic [3:0]  pattern_b,
  output logic        pattern_valid,
  output logic [19:0] pattern_timer,
  output logic [7:0]  pattern_index,
  output logic        countdown_busy,
  output state_e      state_dbg
);

  localparam logic [27:0] CD_LAST    = 28'(COUNTDOWN_CYCLES - 1);
  localparam logic [27:0] GAP_LAST   = 28'(GAP_CYCLES - 1);
  localparam logic [19:0] WIN_LAST   = 20'(WINDOW_CYCLES - 1);
  localparam logic [7:0]  LAST_INDEX = 8'(NUM_PATTERNS);

  state_e      state_q;
  logic [27:0] cnt_q;
  logic        active_q;
  logic        over_q;
  logic [3:0]  pat_a_q;
  logic [3:0]  pat_b_q;
  logic        valid_q;
  logic [19:0] timer_q;
  logic [7:0]  index_q;
  logic        busy_q;

  logic        waiting;
  logic        running;
  logic        accept;
  logic        abort_hit;
  logic        show_done;
  logic [15:0] seed_eff;
  logic [15:0] lfsr_value;

  assign waiting   = (state_q == ST_IDLE) || (state_q == ST_OVER);
  assign running   = (state_q == ST_COUNTDOWN) || (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign accept    = waiting && start && !abort;
  assign abort_hit = running && abort;
  // The LFSR only advances as a prompt ends normally, never on abort.
  assign show_done = (state_q == ST_SHOW) && !abort && (timer_q == WIN_LAST);
  assign seed_eff  = (seed == 16'h0000) ? DEFAULT_SEED : seed;

  lfsr16 #(
    .RESET_VALUE(DEFAULT_SEED)
  ) u_lfsr (
    .clk_i  (clock),
    .rst_ni (reset),
    .load_i (accept),
    .step_i (show_done),
    .seed_i (seed_eff),
    .value_o(lfsr_value)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      active_q <= 1'b0;
      over_q   <= 1'b0;
      pat_a_q  <= ARROW_NONE;
      pat_b_q  <= ARROW_NONE;
      valid_q  <= 1'b0;
      timer_q  <= '0;
      index_q  <= '0;
      busy_q   <= 1'b0;
    end else if (abort_hit) begin
      state_q  <= ST_OVER;
      cnt_q    <= '0;
      active_q <= 1'b0;
      over_q   <= 1'b1;
      pat_a_q  <= ARROW_NONE;
      pat_b_q  <= ARROW_NONE;
      valid_q  <= 1'b0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (accept) begin
            state_q <= ST_COUNTDOWN;
            cnt_q   <= '0;
            over_q  <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          if (cnt_q == CD_LAST) begin
            state_q  <= ST_SHOW;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            active_q <= 1'b1;
            pat_a_q  <= arrow_of(lfsr_value[1:0]);
            pat_b_q  <= arrow_of(lfsr_value[3:2]);
            valid_q  <= 1'b1;
            timer_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 28'd1;
          end
        end
        ST_SHOW: begin
          if (timer_q == WIN_LAST) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
            pat_a_q <= ARROW_NONE;
            pat_b_q <= ARROW_NONE;
            valid_q <= 1'b0;
            timer_q <= '0;
            index_q <= index_q + 8'd1;
          end else begin
            timer_q <= timer_q + 20'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (index_q == LAST_INDEX) begin
              state_q  <= ST_OVER;
              active_q <= 1'b0;
              over_q   <= 1'b1;
            end else begin
              state_q <= ST_SHOW;
              pat_a_q <= arrow_of(lfsr_value[1:0]);
              pat_b_q <= arrow_of(lfsr_value[3:2]);
              valid_q <= 1'b1;
              timer_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 28'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign game_active    = active_q;
  assign game_over      = over_q;
  assign pattern_a      = pat_a_q;
  assign pattern_b      = pat_b_q;
  assign pattern_valid  = valid_q;
  assign pattern_timer  = timer_q;
  assign pattern_index  = index_q;
  assign countdown_busy = busy_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random start/abort
// traffic, compared every cycle against a round-timeline reference model.
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;

  localparam int CD     = 4;
  localparam int W      = 8;
  localparam int G      = 2;
  localparam int N      = 3;
  localparam int PERIOD = W + G;
  localparam int ROUND_LEN = CD + N * PERIOD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seed  = 16'h0;
  logic        game_active, game_over, pattern_valid, countdown_busy;
  logic [3:0]  pattern_a, pattern_b;
  logic [19:0] pattern_timer;
  logic [7:0]  pattern_index;
  state_e      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 in round (m_k cycles since accept), 2 over.
  int          m_mode = 0;
  int          m_k = 0;
  int          m_over_idx = 0;
  logic [15:0] m_seed = 16'h0;

  pattern_sequencer #(
    .NUM_PATTERNS    (N),
    .WINDOW_CYCLES   (W),
    .GAP_CYCLES      (G),
    .COUNTDOWN_CYCLES(CD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .game_active   (game_active),
    .game_over     (game_over),
    .pattern_a     (pattern_a),
    .pattern_b     (pattern_b),
    .pattern_valid (pattern_valid),
    .pattern_timer (pattern_timer),
    .pattern_index (pattern_index),
    .countdown_busy(countdown_busy),
    .state_dbg     (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s, input int steps);
    logic [15:0] l;
    logic fb;
    l = s;
    for (int i = 0; i < steps; i++) begin
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      l  = {l[14:0], fb};
    end
    return l;
  endfunction

  function automatic int ref_index(input int k);
    int j;
    if (k < CD) return 0;
    j = k - CD;
    return (j / PERIOD) + (((j % PERIOD) >= W) ? 1 : 0);
  endfunction

  task automatic model_edge();
    if (m_mode == 1) begin
      if (abort) begin
        m_over_idx = ref_index(m_k);
        m_mode = 2;
      end else begin
        m_k++;
        if (m_k == ROUND_LEN) begin
          m_mode = 2;
          m_over_idx = N;
        end
      end
    end else if (start && !abort) begin
      m_mode = 1;
      m_k = 0;
      m_seed = (seed == 16'h0) ? 16'hACE1 : seed;
    end
  endtask

  task automatic check_outputs();
    logic ea, eo, ev, eb;
    logic [3:0]  epa, epb;
    logic [19:0] et;
    logic [7:0]  ei;
    logic [15:0] l;
    int j, p, r;
    ea = 0; eo = 0; ev = 0; eb = 0; epa = 0; epb = 0; et = 0; ei = 0;
    if (m_mode == 2) begin
      eo = 1;
      ei = 8'(m_over_idx);
    end else if (m_mode == 1) begin
      if (m_k < CD) begin
        eb = 1;
      end else begin
        j = m_k - CD;
        p = j / PERIOD;
        r = j % PERIOD;
        ea = 1;
        ei = 8'(ref_index(m_k));
        if (r < W) begin
          ev  = 1;
          et  = 20'(r);
          l   = ref_lfsr(m_seed, p);
          epa = 4'b0001 << l[1:0];
          epb = 4'b0001 << l[3:2];
        end
      end
    end
    check("game_active", game_active, ea);
    check("game_over", game_over, eo);
    check("pattern_valid", pattern_valid, ev);
    check("countdown_busy", countdown_busy, eb);
    check("pattern_a", pattern_a, epa);
    check("pattern_b", pattern_b, epb);
    check("pattern_timer", pattern_timer, et);
    check("pattern_index", pattern_index, ei);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 200 && m_mode == 1 && m_k < target; i++) step();
  endtask

  task automatic accept_round(input logic [15:0] s);
    start = 1'b1;
    seed  = s;
    step();
    start = 1'b0;
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    check("rst_valid", pattern_valid, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    repeat (3) step();

    // Scenario 1: asynchronous reset mid-SHOW
    accept_round(16'hACE1);
    run_to(CD + 2);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_valid", pattern_valid, 1'b0);
    check("async_rst_active", game_active, 1'b0);
    check("async_rst_pat_a", pattern_a, 4'b0000);
    check("async_rst_timer", pattern_timer, 20'd0);
    check("async_rst_over", game_over, 1'b0);
    m_mode = 0;
    m_over_idx = 0;
    repeat (2) step();
    reset = 1'b1;
    step();
    check("post_rst_state", state_dbg, ST_IDLE);

    // Scenarios 2-4: full round with seed ACE1
    accept_round(16'hACE1);
    check("s2_busy", countdown_busy, 1'b1);
    lat = 0;
    while (m_k < CD) begin step(); lat++; end
    check("s2_pat_a", pattern_a, 4'b0010);
    check("s2_pat_b", pattern_b, 4'b0001);
    run_to(CD + PERIOD);
    lat = CD + PERIOD;
    check("s3_pat_a", pattern_a, 4'b1000);
    check("s3_pat_b", pattern_b, 4'b0001);
    check("s3_index", pattern_index, 8'd1);
    while (game_over !== 1'b1 && lat < 60) begin step(); lat++; end
    check("s4_over_latency", lat, ROUND_LEN);
    check("s4_index", pattern_index, 8'd3);
    repeat (5) step();
    check("s4_over_held", game_over, 1'b1);

    // Scenario 5/6: restart from OVER, then abort in second prompt at timer 5
    accept_round(16'hACE1);
    check("restart_over_clear", game_over, 1'b0);
    check("restart_busy", countdown_busy, 1'b1);
    run_to(CD + PERIOD + 5);
    check("s5_timer_before", pattern_timer, 20'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("s5_over", game_over, 1'b1);
    check("s5_valid", pattern_valid, 1'b0);
    check("s5_timer", pattern_timer, 20'd0);
    check("s5_index", pattern_index, 8'd1);
    repeat (2) step();

    // Scenario 6: seed 0 falls back to the default seed
    accept_round(16'h0000);
    run_to(CD);
    check("s6_pat_a", pattern_a, 4'b0010);
    check("s6_pat_b", pattern_b, 4'b0001);
    run_to(ROUND_LEN);
    repeat (2) step();

    // Simultaneous start and abort while over: no action
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_ignored", game_over, 1'b1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 60) == 0);
      seed  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
      step();
    end
    start = 1'b0;
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
